// File: rtl/sd_cmd_phys.sv
// SD host CMD-line physical layer: serialises a 48-bit command frame with CRC7,
// then waits for, deserialises and CRC-checks the card response.
module sd_cmd_phys #(
    parameter int RESP_BITS = 48,
    parameter int TIMEOUT   = 64
) (
    input  logic                 sd_clock,
    input  logic                 reset,
    input  logic                 strobe_in,
    input  logic                 ack_in,
    input  logic                 idle_in,
    input  logic [39:0]          cmd_to_send,
    inout  wire                  cmd_pin,
    output logic                 ack_out,
    output logic                 strobe_out,
    output logic [RESP_BITS-1:0] response,
    output logic                 timeout_error,
    output logic                 crc_error
);

    localparam int MAXC = (RESP_BITS > TIMEOUT) ? RESP_BITS : TIMEOUT;
    localparam int CW   = (MAXC > 64) ? $clog2(MAXC) : 6;

    typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECEIVE, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [46:0]          tx_q, tx_d;
    logic                 dout_q, dout_d;
    logic                 oe_q, oe_d;
    logic [RESP_BITS-2:0] rx_q, rx_d;
    logic [RESP_BITS-1:0] resp_q, resp_d;
    logic                 ack_q, ack_d;
    logic                 strobe_q, strobe_d;
    logic                 tmo_q, tmo_d;
    logic                 crc_err_q, crc_err_d;

    logic                 pin_in;
    logic [RESP_BITS-1:0] rx_full;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_cmd(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    function automatic logic [6:0] crc7_resp(input logic [RESP_BITS-1:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = RESP_BITS - 1; i >= 8; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    assign cmd_pin = oe_q ? dout_q : 1'bz;
    assign pin_in  = cmd_pin;
    assign rx_full = {rx_q, pin_in};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        dout_d    = dout_q;
        oe_d      = oe_q;
        rx_d      = rx_q;
        resp_d    = resp_q;
        ack_d     = 1'b0;
        strobe_d  = strobe_q;
        tmo_d     = tmo_q;
        crc_err_d = crc_err_q;
        if (idle_in) begin
            state_d   = IDLE;
            cnt_d     = '0;
            dout_d    = 1'b1;
            oe_d      = 1'b1;
            strobe_d  = 1'b0;
            tmo_d     = 1'b0;
            crc_err_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    dout_d = 1'b1;
                    oe_d   = 1'b1;
                    if (strobe_in) begin
                        tx_d      = {cmd_to_send[38:0], crc7_cmd(cmd_to_send), 1'b1};
                        dout_d    = cmd_to_send[39];
                        cnt_d     = '0;
                        ack_d     = 1'b1;
                        tmo_d     = 1'b0;
                        crc_err_d = 1'b0;
                        state_d   = SEND;
                    end
                end
                SEND: begin
                    if (cnt_q == CW'(47)) begin
                        oe_d    = 1'b0;
                        dout_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = WAIT_RESP;
                    end else begin
                        dout_d = tx_q[46];
                        tx_d   = {tx_q[45:0], 1'b0};
                        cnt_d  = cnt_q + 1'b1;
                    end
                end
                WAIT_RESP: begin
                    // Only a driven 0 counts as a start bit; it lands in the MSB
                    if (pin_in == 1'b0) begin
                        rx_d    = '0;
                        cnt_d   = '0;
                        state_d = RECEIVE;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        tmo_d    = 1'b1;
                        strobe_d = 1'b1;
                        state_d  = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RECEIVE: begin
                    rx_d  = rx_full[RESP_BITS-2:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(RESP_BITS - 2)) begin
                        resp_d    = rx_full;
                        crc_err_d = (crc7_resp(rx_full) != rx_full[7:1]);
                        strobe_d  = 1'b1;
                        state_d   = DONE;
                    end
                end
                DONE: begin
                    if (ack_in) begin
                        strobe_d = 1'b0;
                        oe_d     = 1'b1;
                        dout_d   = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tx_q      <= '0;
            dout_q    <= 1'b1;
            oe_q      <= 1'b1;
            rx_q      <= '0;
            resp_q    <= '0;
            ack_q     <= 1'b0;
            strobe_q  <= 1'b0;
            tmo_q     <= 1'b0;
            crc_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
            dout_q    <= dout_d;
            oe_q      <= oe_d;
            rx_q      <= rx_d;
            resp_q    <= resp_d;
            ack_q     <= ack_d;
            strobe_q  <= strobe_d;
            tmo_q     <= tmo_d;
            crc_err_q <= crc_err_d;
        end
    end

    assign ack_out       = ack_q;
    assign strobe_out    = strobe_q;
    assign response      = resp_q;
    assign timeout_error = tmo_q;
    assign crc_error     = crc_err_q;

endmodule

// File: tb/tb_sd_cmd_phys.sv
// Bench for sd_cmd_phys: directed and randomized command/response transactions
// against a CRC7 long-division reference model and a simple card model.
module tb_sd_cmd_phys;

    localparam int RESP_BITS = 48;
    localparam int TIMEOUT   = 64;

    logic                 sd_clock;
    logic                 reset;
    logic                 strobe_in;
    logic                 ack_in;
    logic                 idle_in;
    logic [39:0]          cmd_to_send;
    wire                  cmd_pin;
    logic                 ack_out;
    logic                 strobe_out;
    logic [RESP_BITS-1:0] response;
    logic                 timeout_error;
    logic                 crc_error;

    logic card_oe;
    logic card_bit;

    int checks = 0;
    int errors = 0;

    pullup (cmd_pin);
    assign cmd_pin = card_oe ? card_bit : 1'bz;

    sd_cmd_phys #(.RESP_BITS(RESP_BITS), .TIMEOUT(TIMEOUT)) dut (
        .sd_clock      (sd_clock),
        .reset         (reset),
        .strobe_in     (strobe_in),
        .ack_in        (ack_in),
        .idle_in       (idle_in),
        .cmd_to_send   (cmd_to_send),
        .cmd_pin       (cmd_pin),
        .ack_out       (ack_out),
        .strobe_out    (strobe_out),
        .response      (response),
        .timeout_error (timeout_error),
        .crc_error     (crc_error)
    );

    initial sd_clock = 1'b0;
    always #5 sd_clock = ~sd_clock;

    // Remainder of d(x)*x^7 divided by x^7+x^3+1, by mod-2 long division
    function automatic logic [6:0] crc_model(input logic [39:0] d);
        logic [46:0] v;
        logic [46:0] g;
        v = {d, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (v[i]) begin
                g = 47'h89 << (i - 7);
                v = v ^ g;
            end
        end
        return v[6:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [39:0] cmd);
        logic [47:0] got;
        logic [47:0] exp;
        @(negedge sd_clock);
        strobe_in   = 1'b1;
        cmd_to_send = cmd;
        @(negedge sd_clock);
        strobe_in   = 1'b0;
        cmd_to_send = {8'($urandom), $urandom};
        chk("ack_pulse", 64'(ack_out), 64'd1);
        for (int j = 0; j < 48; j++) begin
            got[47-j] = cmd_pin;
            if (j == 1) chk("ack_one_cycle", 64'(ack_out), 64'd0);
            @(negedge sd_clock);
        end
        exp = {cmd, crc_model(cmd), 1'b1};
        chk("cmd_frame", 64'(got), 64'(exp));
        chk("released_pin", 64'(cmd_pin), 64'd1);
    endtask

    task automatic card_reply(input logic [RESP_BITS-1:0] frame, input int delay,
                              input logic bad);
        repeat (delay) @(negedge sd_clock);
        for (int j = 0; j < RESP_BITS; j++) begin
            card_oe  = 1'b1;
            card_bit = frame[RESP_BITS-1-j];
            @(negedge sd_clock);
        end
        card_oe = 1'b0;
        chk("rx_strobe", 64'(strobe_out), 64'd1);
        chk("rx_response", 64'(response), 64'(frame));
        chk("rx_crc_error", 64'(crc_error), 64'(bad));
        chk("rx_timeout_error", 64'(timeout_error), 64'd0);
    endtask

    task automatic expect_timeout();
        int n;
        n = 0;
        while (!strobe_out && n < 4 * TIMEOUT) begin
            @(negedge sd_clock);
            n++;
        end
        chk("timeout_latency", 64'(n), 64'(TIMEOUT));
        chk("timeout_flag", 64'(timeout_error), 64'd1);
        chk("timeout_crc_flag", 64'(crc_error), 64'd0);
    endtask

    task automatic do_ack();
        ack_in = 1'b1;
        @(negedge sd_clock);
        ack_in = 1'b0;
        chk("ack_strobe_low", 64'(strobe_out), 64'd0);
        chk("ack_pin_high", 64'(cmd_pin), 64'd1);
    endtask

    function automatic logic [RESP_BITS-1:0] make_r1(input logic [37:0] body, input logic bad);
        logic [39:0]          h;
        logic [RESP_BITS-1:0] f;
        h = {2'b00, body};
        f = {h, crc_model(h), 1'b1};
        if (bad) f[1 + $urandom_range(0, 6)] ^= 1'b1;
        return f;
    endfunction

    logic [RESP_BITS-1:0] fr;
    logic [RESP_BITS-1:0] cmd8_resp;
    logic [39:0]          c;
    logic                 bad;

    initial begin
        reset       = 1'b0;
        strobe_in   = 1'b0;
        ack_in      = 1'b0;
        idle_in     = 1'b0;
        cmd_to_send = '0;
        card_oe     = 1'b0;
        card_bit    = 1'b1;
        repeat (2) @(negedge sd_clock);
        chk("rst_pin", 64'(cmd_pin), 64'd1);
        chk("rst_ack", 64'(ack_out), 64'd0);
        chk("rst_strobe", 64'(strobe_out), 64'd0);
        chk("rst_resp", 64'(response), 64'd0);
        chk("rst_flags", 64'({timeout_error, crc_error}), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge sd_clock);

        // CMD0, nobody answers
        send_cmd(40'h40_0000_0000);
        expect_timeout();
        do_ack();

        // CMD8 with a valid R1 after 5 cycles
        send_cmd(40'h48_0000_01AA);
        cmd8_resp = make_r1(38'h08_0000_01AA, 1'b0);
        card_reply(cmd8_resp, 5, 1'b0);
        ack_in = 1'b1;
        @(negedge sd_clock);
        chk("ack_in_strobe", 64'(strobe_out), 64'd0);
        ack_in = 1'b0;

        // CMD7 timeout, then abort while in DONE
        send_cmd({2'b01, 6'd7, 32'h1234_0000});
        expect_timeout();
        idle_in = 1'b1;
        @(negedge sd_clock);
        idle_in = 1'b0;
        chk("abort_done_strobe", 64'(strobe_out), 64'd0);
        chk("abort_done_tmo", 64'(timeout_error), 64'd0);
        chk("abort_done_pin", 64'(cmd_pin), 64'd1);
        chk("abort_done_resp_held", 64'(response), 64'(cmd8_resp));

        // Bad CRC
        c = {2'b01, 6'd17, $urandom};
        send_cmd(c);
        fr = make_r1({6'd17, $urandom}, 1'b1);
        card_reply(fr, 3, 1'b1);
        do_ack();

        // Randomized transactions
        for (int k = 0; k < 8; k++) begin
            c   = {2'b01, 6'($urandom), $urandom};
            bad = 1'($urandom);
            send_cmd(c);
            fr = make_r1({6'($urandom), $urandom}, bad);
            card_reply(fr, $urandom_range(0, TIMEOUT - 2), bad);
            if (k == 3) begin
                ack_in = 1'b0;
                repeat (3) @(negedge sd_clock);
                chk("done_held", 64'(strobe_out), 64'd1);
            end
            do_ack();
        end

        // Abort during SEND, then a normal transaction
        @(negedge sd_clock);
        strobe_in   = 1'b1;
        cmd_to_send = 40'h4D_0000_0000;
        @(negedge sd_clock);
        strobe_in = 1'b0;
        repeat (5) @(negedge sd_clock);
        idle_in = 1'b1;
        @(negedge sd_clock);
        idle_in = 1'b0;
        chk("abort_send_pin", 64'(cmd_pin), 64'd1);
        chk("abort_send_strobe", 64'(strobe_out), 64'd0);
        repeat (3) @(negedge sd_clock);
        chk("abort_send_idle_pin", 64'(cmd_pin), 64'd1);
        send_cmd(40'h4D_0001_0000);
        fr = make_r1(38'h0D_0000_0900, 1'b0);
        card_reply(fr, 2, 1'b0);
        do_ack();

        // Asynchronous reset in the middle of SEND
        @(negedge sd_clock);
        strobe_in   = 1'b1;
        cmd_to_send = 40'h40_0000_0000;
        @(negedge sd_clock);
        strobe_in = 1'b0;
        repeat (10) @(negedge sd_clock);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_pin", 64'(cmd_pin), 64'd1);
        chk("mid_rst_resp", 64'(response), 64'd0);
        chk("mid_rst_outs", 64'({ack_out, strobe_out, timeout_error, crc_error}), 64'd0);
        @(negedge sd_clock);
        reset = 1'b1;
        repeat (60) @(negedge sd_clock);
        chk("post_rst_pin", 64'(cmd_pin), 64'd1);
        chk("post_rst_outs", 64'({ack_out, strobe_out}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_cmd_phys.md
Name: sd_cmd_phys

Overview:
- SD-host CMD-line physical layer, between the command controller and the bidirectional CMD pad.
- On a strobe it serialises a 40-bit command, appends CRC7 and the end bit, and drives the 48-bit frame MSB-first.
- It then releases the line, waits for the card's response start bit, and deserialises and CRC-checks the response.
- It reports the result through a strobe/ack handshake.

Parameters:
RESP_BITS, 48, response frame length in bits, including start and end bits (48 = R1-type).
TIMEOUT, 64, max sd_clock cycles to wait for the response start bit (NCR limit).

Ports:
sd_clock  input  1  sole clock; all logic on rising edge
reset  input  1  asynchronous, active-low; 0 = reset
strobe_in  input  1  start request; sampled only in IDLE
ack_in  input  1  controller acknowledges a completed transaction
idle_in  input  1  synchronous abort/force-idle; highest priority after reset
cmd_to_send  input  40  [39]=start(0), [38]=transmission(1), [37:32]=index, [31:0]=argument
cmd_pin  inout  1  SD CMD line; driven when output enable is set, else high-Z
ack_out  output  1  one-cycle pulse when a command is accepted (IDLE->SEND)
strobe_out  output  1  high in DONE; transaction result valid
response  output  RESP_BITS  captured response frame, first-received bit at MSB
timeout_error  output  1  no start bit within TIMEOUT cycles; valid with strobe_out
crc_error  output  1  response CRC7 mismatch; valid with strobe_out

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; cmd_pin driven 1.
  - ack_out, strobe_out, timeout_error, crc_error = 0; response = 0; counters and shift registers cleared.
- FSM states: IDLE, SEND, WAIT_RESP, RECEIVE, DONE.
- Priority when out of reset: idle_in=1 forces IDLE next edge from any state and clears the error flags; response is held.
- IDLE:
  - cmd_pin driven 1.
  - strobe_in=1 (and idle_in=0): latch cmd_to_send, compute CRC7 over the 40 bits, pulse ack_out for one cycle, go to SEND.
- CRC7: polynomial x^7+x^3+1, register initialised to 0, bits fed MSB first.
- SEND:
  - Drives 48 bits on consecutive cycles: cmd_to_send[39:0], then CRC7[6:0], then end bit 1.
  - First bit is on cmd_pin the cycle after the accept edge.
  - A 6-bit counter indexes the bits; after bit 47, release cmd_pin (high-Z) and go to WAIT_RESP.
  - cmd_to_send changing during SEND has no effect.
- WAIT_RESP:
  - cmd_pin high-Z; sample each rising edge.
  - Sample 0 → the start bit is stored as response bit RESP_BITS-1; go to RECEIVE.
  - TIMEOUT cycles elapse with no 0 → timeout_error=1; go to DONE.
  - A high-Z or 1 sample counts as no start bit.
- RECEIVE:
  - Shift in the remaining RESP_BITS-1 bits MSB-first.
  - After the last bit, compare CRC7 over bits [RESP_BITS-1:8] with bits [7:1]; mismatch → crc_error=1.
  - Go to DONE. The end bit is stored but not checked.
- DONE:
  - strobe_out=1; response and error flags stable.
  - Stay until ack_in=1, then go to IDLE next edge, strobe_out=0, drive cmd_pin 1.
  - ack_in outside DONE is ignored.
- Error flags are cleared on the next accepted command.
- strobe_in held high through DONE→IDLE is treated as a new request in IDLE.

Test Plan:
- Reset: assert reset=0 mid-SEND → cmd_pin=1 immediately, all outputs 0, state IDLE; release and remain idle with strobe_in=0.
- CMD0: cmd_to_send=40'h40_0000_0000, strobe_in pulse → ack_out pulse one cycle later; cmd_pin shows 48'h40_0000_0000_95 MSB-first over 48 consecutive cycles, then high-Z.
- CMD8 + valid R1: cmd_to_send=40'h48_0000_01AA → frame ends 8'h87. Card model drives 48'h08_0000_01AA_xx with correct CRC after 5 cycles → strobe_out=1, response equals the driven frame, crc_error=0. After ack_in=1, strobe_out=0 next cycle.
- Timeout: send CMD7 (index 6'd7) with no card reply → strobe_out=1 exactly TIMEOUT cycles after release, timeout_error=1.
- Bad CRC: card returns a frame with one CRC bit flipped → crc_error=1, timeout_error=0.
- Abort: idle_in=1 during SEND, and separately during DONE → IDLE next edge, cmd_pin=1, strobe_out=0; a following strobe_in is accepted normally.
